// File: rtl/display_scanner.sv
// display_scanner
//   Time-multiplexing scan controller for a 4-digit seven-segment display.
//   A prescaler divides clk down to one digit slot every DIV cycles and steps
//   the 2-bit digit index cnt. Display values are double-buffered: load
//   captures into a shadow copy, and the shadow is committed to the visible
//   display registers only when cnt wraps from 3 to 0, so a frame never mixes
//   old and new digits.
//
//   Optional feature: define DISPLAY_SCANNER_LZB_EN to enable leading-zero
//   blanking. Without it, blank is tied low and no blanking logic exists.

module display_scanner #(
   parameter int DIV   = 100000,
   parameter int DIV_W = $clog2(DIV)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic        load,
   output logic [1:0]  cnt,
   output logic [3:0]  digit,
   output logic        dp,
   output logic        blank,
   output logic        upd_done
);

   // Last prescaler count of a slot; the tick fires while pre sits here.
   localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);

   // Scan timing state
   logic [DIV_W-1:0] pre_q, pre_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             tick;
   logic             frame_end;

   // Double buffer state
   logic [15:0]      shadow_q, shadow_d;
   logic [3:0]       shadow_dp_q, shadow_dp_d;
   logic             pending_q, pending_d;
   logic [15:0]      disp_q, disp_d;
   logic [3:0]       disp_dp_q, disp_dp_d;

   // Registered outputs
   logic [3:0]       digit_q, digit_d;
   logic             dp_q, dp_d;
   logic             upd_q, upd_d;

   assign tick      = (pre_q == PRE_LAST);
   // The frame boundary is the tick that carries cnt from 3 back to 0.
   assign frame_end = tick && (cnt_q == 2'd3);

   // Prescaler and digit index: hold each index for exactly DIV cycles.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      pre_d = pre_q + DIV_W'(1);
      cnt_d = cnt_q;
      if (tick) begin
         pre_d = '0;
         cnt_d = cnt_q + 2'd1;
      end
   end

   // Scan counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         cnt_q <= 2'd0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every
         // register samples the pre-edge value of every other register.
         pre_q <= pre_d;
         cnt_q <= cnt_d;
      end
   end

   // Double buffer: loads land in the shadow unless they coincide with a
   // frame boundary, in which case they go straight to the display and the
   // shadow is bypassed. A load always supersedes anything still pending.
   always_comb begin
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      pending_d   = pending_q;
      disp_d      = disp_q;
      disp_dp_d   = disp_dp_q;
      upd_d       = 1'b0;

      if (frame_end && load) begin
         disp_d    = value;
         disp_dp_d = dp_in;
         pending_d = 1'b0;
         upd_d     = 1'b1;
      end else if (frame_end && pending_q) begin
         disp_d    = shadow_q;
         disp_dp_d = shadow_dp_q;
         pending_d = 1'b0;
         upd_d     = 1'b1;
      end else if (load) begin
         shadow_d    = value;
         shadow_dp_d = dp_in;
         pending_d   = 1'b1;
      end
   end

   // Buffer registers, including the update strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the display and shadow storage are reset too: their contents
         // drive the outputs directly, and a reset must also drop any pending
         // load rather than let it surface afterwards.
         shadow_q    <= 16'h0000;
         shadow_dp_q <= 4'h0;
         pending_q   <= 1'b0;
         disp_q      <= 16'h0000;
         disp_dp_q   <= 4'h0;
         upd_q       <= 1'b0;
      end else begin
         shadow_q    <= shadow_d;
         shadow_dp_q <= shadow_dp_d;
         pending_q   <= pending_d;
         disp_q      <= disp_d;
         disp_dp_q   <= disp_dp_d;
         upd_q       <= upd_d;
      end
   end

   // Digit and decimal point selection from the next index and next display
   // contents, so the registered outputs switch on the same edge as cnt.
   always_comb begin
      digit_d = disp_d[3:0];
      case (cnt_d)
         2'd0:    digit_d = disp_d[3:0];
         2'd1:    digit_d = disp_d[7:4];
         2'd2:    digit_d = disp_d[11:8];
         default: digit_d = disp_d[15:12];
      endcase
      dp_d = disp_dp_d[cnt_d];
   end

   // Output registers for digit and decimal point.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q <= 4'h0;
         dp_q    <= 1'b0;
      end else begin
         digit_q <= digit_d;
         dp_q    <= dp_d;
      end
   end

`ifdef DISPLAY_SCANNER_LZB_EN
   logic blank_q, blank_d;

   // Leading-zero blanking: digit k (1..3) goes dark when it and every more
   // significant nibble are zero and its own decimal point is off. Digit 0
   // always shows, so an all-zero value still displays a single 0.
   always_comb begin
      blank_d = 1'b0;
      case (cnt_d)
         2'd1:    blank_d = (disp_d[15:4]  == 12'h000) && !disp_dp_d[1];
         2'd2:    blank_d = (disp_d[15:8]  == 8'h00)   && !disp_dp_d[2];
         2'd3:    blank_d = (disp_d[15:12] == 4'h0)    && !disp_dp_d[3];
         default: blank_d = 1'b0;
      endcase
   end

   // Blank register, aligned with cnt like the other outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_q <= 1'b0;
      end else begin
         blank_q <= blank_d;
      end
   end

   assign blank = blank_q;
`else
   assign blank = 1'b0;
`endif

   assign cnt      = cnt_q;
   assign digit    = digit_q;
   assign dp       = dp_q;
   assign upd_done = upd_q;

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner
//   Scoreboard bench for display_scanner with DIV=4. The stimulus process
//   queues the expected contents of every digit slot ahead of time; a monitor
//   pops one entry each time cnt moves and checks every cycle of the slot,
//   including slot length and the single-cycle upd_done pulse.
//   Honours DISPLAY_SCANNER_LZB_EN for the expected blank values.

module tb_display_scanner;

   localparam int DIV = 4;

   typedef struct packed {
      logic [1:0] c;
      logic [3:0] d;
      logic       p;
      logic       b;
      logic       u;
   } slot_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = 16'h0000;
   logic [3:0]  dp_in = 4'h0;
   logic        load = 1'b0;
   logic [1:0]  cnt;
   logic [3:0]  digit;
   logic        dp;
   logic        blank;
   logic        upd_done;

   slot_t exp_q[$];
   slot_t cur;
   int    total = 0;
   int    bad = 0;
   int    e = 0;
   int    slot_len = 0;
   bit    started = 1'b0;
   logic [1:0] prev_cnt = 2'd0;

   display_scanner #(.DIV(DIV)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .value    (value),
      .dp_in    (dp_in),
      .load     (load),
      .cnt      (cnt),
      .digit    (digit),
      .dp       (dp),
      .blank    (blank),
      .upd_done (upd_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_blank(input logic [15:0] d, input logic [3:0] p, input int c);
`ifdef DISPLAY_SCANNER_LZB_EN
      logic [15:0] hi;
      hi = d >> (4 * c);
      return (c != 0) && (hi == 16'h0000) && !p[c];
`else
      return 1'b0;
`endif
   endfunction

   // Queue expected slots lo..hi of one frame showing display value d.
   task automatic push_slots(input logic [15:0] d, input logic [3:0] p, input logic u,
                             input int lo, input int hi);
      for (int c = lo; c <= hi; c++) begin
         slot_t s;
         s.c = 2'(c);
         s.d = 4'(d >> (4 * c));
         s.p = p[c];
         s.b = exp_blank(d, p, c);
         s.u = u && (c == 0);
         exp_q.push_back(s);
      end
   endtask

   // Advance to 1 time unit after rising edge n (counted from reset release).
   task automatic go_to(input int n);
      while (e < n) begin
         @(posedge clk);
         e++;
      end
      #1;
   endtask

   // Present a load so that it is sampled on rising edge n.
   task automatic do_load(input int n, input logic [15:0] v, input logic [3:0] p);
      go_to(n - 1);
      value = v;
      dp_in = p;
      load  = 1'b1;
      go_to(n);
      load  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cnt"}, cnt, 2'd0);
      check({tag, "_digit"}, digit, 4'h0);
      check({tag, "_dp"}, dp, 1'b0);
      check({tag, "_blank"}, blank, 1'b0);
      check({tag, "_upd"}, upd_done, 1'b0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      e = 0;
   endtask

   // Monitor: one scoreboard entry per slot, checked on every cycle of it.
   always @(negedge clk) begin
      if (!rst_n) begin
         slot_len = 0;
         started  = 1'b0;
         prev_cnt = 2'd0;
         cur      = '0;
      end else begin
         if (cnt !== prev_cnt) begin
            check(started ? "slot_len" : "first_slot_len", slot_len, started ? DIV : DIV - 1);
            check("sb_entry_avail", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            started  = 1'b1;
            slot_len = 0;
            prev_cnt = cnt;
         end
         slot_len++;
         check("cnt", cnt, cur.c);
         check("digit", digit, cur.d);
         check("dp", dp, cur.p);
         check("blank", blank, cur.b);
         check("upd_done", upd_done, (started && slot_len == 1) ? cur.u : 1'b0);
      end
   end

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");

      // Free run from reset: display stays zero through two frames.
      push_slots(16'h0000, 4'h0, 1'b0, 1, 3);   // E4..E12
      push_slots(16'h0000, 4'h0, 1'b0, 0, 3);   // E16..E28
      release_reset();

      // Single load while cnt=1, committed at the E32 boundary.
      do_load(21, 16'h1234, 4'b0100);
      push_slots(16'h1234, 4'b0100, 1'b1, 0, 3); // E32..E44

      // Two loads in one frame: only the later one is shown, one pulse.
      push_slots(16'h5555, 4'h0, 1'b1, 0, 3);    // E48..E60
      do_load(37, 16'hAAAA, 4'h0);
      do_load(42, 16'h5555, 4'h0);

      // Load in the exact boundary cycle bypasses the shadow.
      push_slots(16'h00FF, 4'h0, 1'b1, 0, 3);    // E64..E76
      do_load(64, 16'h00FF, 4'h0);

      // Leading-zero patterns.
      push_slots(16'h0007, 4'h0, 1'b1, 0, 3);    // E80..E92
      do_load(70, 16'h0007, 4'h0);
      push_slots(16'h0000, 4'h0, 1'b1, 0, 3);    // E96..E108
      do_load(85, 16'h0000, 4'h0);
      push_slots(16'h0000, 4'b0100, 1'b1, 0, 3); // E112..E124
      do_load(100, 16'h0000, 4'b0100);

      // Reset mid-frame at cnt=2 with a load pending.
      push_slots(16'h0000, 4'b0100, 1'b0, 0, 2); // E128..E136
      do_load(130, 16'h9999, 4'hF);
      go_to(137);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      check("sb_drained_at_reset", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("held_rst");

      // After release the discarded load never appears.
      push_slots(16'h0000, 4'h0, 1'b0, 1, 3);
      push_slots(16'h0000, 4'h0, 1'b0, 0, 3);
      release_reset();
      go_to(30);
      check("sb_empty_at_end", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
